byte_mem_loader: RTL and testbench

//  Upstream fill stage for the 8-bit block-RAM byte store (ram_style "block").

---
 rtl/byte_mem_loader.sv | 152 +++++++++++++++
 tb/tb_byte_mem_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_mem_loader.sv
// byte_mem_loader: fill stage for a byte-wide block-RAM store.
// An optional pre-clear writes FILL_VAL to every address. A valid/ready byte
// stream is then written to consecutive addresses starting at 0. The stored
// word count and an overflow flag are reported. Beats beyond DEPTH are drained
// and discarded until s_last is seen.
module byte_mem_loader #(
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 1024,
    parameter int                ADDR_W   = 10,
    parameter logic [DATA_W-1:0] FILL_VAL = 8'hAA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear_mode,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   accept;

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and the combinational handshake/status outputs.
    always_comb begin
        state_next = state_reg;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = clear_mode ? S_CLEAR : S_LOAD;
                end
            end
            S_CLEAR: begin
                busy = 1'b1;
                // mem_addr tracks the clear write currently on the bus.
                if (mem_addr == LAST_ADDR) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                s_ready = (word_count < DEPTH_CNT);
                accept  = s_valid & s_ready;
                if (accept) begin
                    if (s_last) begin
                        state_next = S_DONE;
                    end else if (word_count == LAST_CNT) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                accept  = s_valid;
                if (s_valid && s_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered memory write port, word counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        word_count <= '0;
                        overflow   <= 1'b0;
                        // The first clear write goes out in the cycle right
                        // after start, so it is issued from IDLE.
                        if (clear_mode) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= '0;
                            mem_wdata <= FILL_VAL;
                        end
                    end
                end
                S_CLEAR: begin
                    if (mem_addr != LAST_ADDR) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= mem_addr + 1'b1;
                        mem_wdata <= FILL_VAL;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= word_count[ADDR_W-1:0];
                        mem_wdata  <= s_data;
                        word_count <= word_count + 1'b1;
                        if (!s_last && word_count == LAST_CNT) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_mem_loader.sv
// Directed testbench for byte_mem_loader with DEPTH=16.
module tb_byte_mem_loader;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic              clear_mode;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic              overflow;

    int n_assert = 0;
    int n_fail   = 0;

    byte_mem_loader #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .FILL_VAL (8'hAA)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear_mode (clear_mode),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Watchdog in case the sequence somehow stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] vals [4];
        logic       vpat [5];
        int         exp_a;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1; vpat[4] = 1'b1;

        // 1: reset held with start asserted
        rst = 1'b0; start = 1'b1; clear_mode = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_word_count", 32'(word_count), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        start = 1'b0;
        rst = 1'b1;
        step();
        check("idle_busy", 32'(busy), 0);

        // 2: plain load of 4 beats
        start = 1'b1; clear_mode = 1'b0;
        step();
        start = 1'b0;
        check("t2_s_ready", 32'(s_ready), 1);
        check("t2_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = vals[i]; s_last = (i == 3);
            step();
            check($sformatf("t2_we%0d", i), 32'(mem_we), 1);
            check($sformatf("t2_addr%0d", i), 32'(mem_addr), 32'(i));
            check($sformatf("t2_data%0d", i), 32'(mem_wdata), 32'(vals[i]));
            check($sformatf("t2_wc%0d", i), 32'(word_count), 32'(i + 1));
            check($sformatf("t2_done%0d", i), 32'(done), 32'(i == 3));
        end
        s_valid = 1'b0; s_last = 1'b0;
        step();
        check("t2_done_after", 32'(done), 0);
        check("t2_we_after", 32'(mem_we), 0);
        check("t2_busy_after", 32'(busy), 0);
        check("t2_wc_hold", 32'(word_count), 4);
        check("t2_overflow", 32'(overflow), 0);

        // 3: clear then load
        start = 1'b1; clear_mode = 1'b1;
        step();
        start = 1'b0; clear_mode = 1'b0;
        check("t3_wc_cleared", 32'(word_count), 0);
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("t3_we%0d", k), 32'(mem_we), 1);
            check($sformatf("t3_addr%0d", k), 32'(mem_addr), 32'(k));
            check($sformatf("t3_data%0d", k), 32'(mem_wdata), 32'h0000_00AA);
            check($sformatf("t3_ready%0d", k), 32'(s_ready), 0);
            check($sformatf("t3_busy%0d", k), 32'(busy), 1);
            step();
        end
        check("t3_we_end", 32'(mem_we), 0);
        check("t3_ready_end", 32'(s_ready), 1);
        check("t3_wc_end", 32'(word_count), 0);

        // 4: backpressure, s_last on invalid cycles must be ignored
        exp_a = 0;
        for (int j = 0; j < 5; j++) begin
            s_valid = vpat[j]; s_data = 8'(5 + j); s_last = (j == 4) || !vpat[j];
            step();
            check($sformatf("t4_we%0d", j), 32'(mem_we), 32'(vpat[j]));
            if (vpat[j]) begin
                check($sformatf("t4_addr%0d", j), 32'(mem_addr), 32'(exp_a));
                check($sformatf("t4_data%0d", j), 32'(mem_wdata), 32'(5 + j));
                exp_a++;
            end
            check($sformatf("t4_done%0d", j), 32'(done), 32'(j == 4));
        end
        s_valid = 1'b0; s_last = 1'b0;
        step();
        check("t4_wc", 32'(word_count), 3);
        check("t4_busy", 32'(busy), 0);

        // 5: overflow and drain
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            s_valid = 1'b1; s_data = 8'(i); s_last = (i == 20);
            step();
            if (i <= DEPTH) begin
                check($sformatf("t5_we%0d", i), 32'(mem_we), 1);
                check($sformatf("t5_addr%0d", i), 32'(mem_addr), 32'(i - 1));
                check($sformatf("t5_data%0d", i), 32'(mem_wdata), 32'(i));
                check($sformatf("t5_wc%0d", i), 32'(word_count), 32'(i));
            end else begin
                check($sformatf("t5_we%0d", i), 32'(mem_we), 0);
                check($sformatf("t5_wc%0d", i), 32'(word_count), 16);
            end
            check($sformatf("t5_ovf%0d", i), 32'(overflow), 32'(i >= DEPTH));
            check($sformatf("t5_done%0d", i), 32'(done), 32'(i == 20));
            check($sformatf("t5_ready%0d", i), 32'(s_ready), 32'(i < 20));
        end
        s_valid = 1'b0; s_last = 1'b0;
        step();
        check("t5_ovf_sticky", 32'(overflow), 1);
        check("t5_wc_hold", 32'(word_count), 16);
        check("t5_done_after", 32'(done), 0);

        // 6: reset mid-load, start ignored while busy, then a fresh load
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_ovf_cleared", 32'(overflow), 0);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 8'(8'h60 + i); s_last = 1'b0;
            start = (i == 1); clear_mode = (i == 1);
            step();
            check($sformatf("t6_wc%0d", i), 32'(word_count), 32'(i + 1));
            check($sformatf("t6_addr%0d", i), 32'(mem_addr), 32'(i));
        end
        start = 1'b0; clear_mode = 1'b0; s_valid = 1'b0;
        rst = 1'b0;
        step();
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_wc", 32'(word_count), 0);
        check("t6_rst_we", 32'(mem_we), 0);
        check("t6_rst_ready", 32'(s_ready), 0);
        rst = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_wc_start", 32'(word_count), 0);
        s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        check("t6_we", 32'(mem_we), 1);
        check("t6_addr", 32'(mem_addr), 0);
        check("t6_data", 32'(mem_wdata), 32'h77);
        check("t6_wc", 32'(word_count), 1);
        check("t6_done", 32'(done), 1);
        check("t6_ovf", 32'(overflow), 0);
        step();
        check("t6_done_after", 32'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
